// File: rtl/cat_rec_pkg.sv
// Shared types and default sizing for the cat-recognizer calculation sequencer.
package cat_rec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam int DEF_AMBA_ADDR_DEPTH = 12;
    localparam int DEF_PIXEL_COUNT     = 1024;
    localparam int DEF_CALC_LATENCY    = 3;

endpackage

// File: rtl/calc_sequencer_if.sv
// Control and shared memory-address bundle between the sequencer and its neighbours.
// CALC_SEQ_PERF_CNT_EN adds the pass_cycles performance counter signal.
interface calc_sequencer_if
    import cat_rec_pkg::*;
#(
    parameter int Amba_Addr_Depth = DEF_AMBA_ADDR_DEPTH
);
    logic                       start;
    logic                       wr_en;
    logic [Amba_Addr_Depth-1:0] wr_addr;
    logic [Amba_Addr_Depth-1:0] mem_addr;
    logic                       mem_wr_en;
    logic                       en_read;
    logic                       get_result;
    logic                       busy;
    logic                       done;
`ifdef CALC_SEQ_PERF_CNT_EN
    logic [15:0]                pass_cycles;

    modport master (
        input  start, wr_en, wr_addr,
        output mem_addr, mem_wr_en, en_read, get_result, busy, done, pass_cycles
    );
    modport slave (
        output start, wr_en, wr_addr,
        input  mem_addr, mem_wr_en, en_read, get_result, busy, done, pass_cycles
    );
`else
    modport master (
        input  start, wr_en, wr_addr,
        output mem_addr, mem_wr_en, en_read, get_result, busy, done
    );
    modport slave (
        output start, wr_en, wr_addr,
        input  mem_addr, mem_wr_en, en_read, get_result, busy, done
    );
`endif
endinterface

// File: rtl/calc_sequencer.sv
// Sequences one recognition pass: address scan, calculator drain, result strobe, done.
// Optional macro CALC_SEQ_PERF_CNT_EN adds a saturating 16-bit pass_cycles counter.
module calc_sequencer
    import cat_rec_pkg::*;
#(
    parameter int Amba_Addr_Depth = DEF_AMBA_ADDR_DEPTH,
    parameter int Pixel_Count     = DEF_PIXEL_COUNT,
    parameter int Calc_Latency    = DEF_CALC_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    calc_sequencer_if.master bus
);

    // state  | meaning
    // IDLE   | APB pass-through, wait for start
    // SCAN   | issue en_read for addresses 0..Pixel_Count-1
    // DRAIN  | wait Calc_Latency cycles for the calculator pipeline
    // RESULT | one-cycle get_result strobe
    // DONE   | pass complete, pass-through, wait for start to drop

    localparam int CntW = ($clog2(Calc_Latency) > 0) ? $clog2(Calc_Latency) : 1;
    localparam logic [Amba_Addr_Depth-1:0] LastAddr = Amba_Addr_Depth'(Pixel_Count - 1);
    localparam logic [CntW-1:0]            LatLoad  = CntW'(Calc_Latency - 1);

    seq_state_t                 state, state_next;
    logic [Amba_Addr_Depth-1:0] scan_addr;
    logic [CntW-1:0]            lat_cnt;
    logic                       pass_thru;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scan_addr <= '0;
            lat_cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: scan_addr <= '0;
                SCAN: begin
                    // Hold at the last address instead of incrementing, so a full-depth scan never wraps.
                    if (scan_addr != LastAddr) scan_addr <= scan_addr + 1'b1;
                    lat_cnt <= LatLoad;
                end
                DRAIN: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        pass_thru      = 1'b0;
        bus.en_read    = 1'b0;
        bus.get_result = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state)
            IDLE: begin
                pass_thru = 1'b1;
                if (bus.start) state_next = SCAN;
            end
            SCAN: begin
                bus.en_read = 1'b1;
                bus.busy    = 1'b1;
                if (!bus.start)                 state_next = IDLE;
                else if (scan_addr == LastAddr) state_next = DRAIN;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (!bus.start)         state_next = IDLE;
                else if (lat_cnt == '0) state_next = RESULT;
            end
            RESULT: begin
                bus.busy       = 1'b1;
                bus.get_result = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                pass_thru = 1'b1;
                bus.done  = 1'b1;
                if (!bus.start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_addr  = pass_thru ? bus.wr_addr : scan_addr;
    assign bus.mem_wr_en = pass_thru & bus.wr_en & ~rst;

`ifdef CALC_SEQ_PERF_CNT_EN
    logic [15:0] pass_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      pass_cycles_q <= '0;
        else if (state == IDLE && state_next == SCAN) pass_cycles_q <= '0;
        else if (bus.busy && pass_cycles_q != 16'hFFFF) pass_cycles_q <= pass_cycles_q + 16'd1;
    end

    assign bus.pass_cycles = pass_cycles_q;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized self-checking bench for calc_sequencer against a pass-timeline reference model.
module tb_calc_sequencer;

    localparam int D   = 12;
    localparam int PC  = 4;
    localparam int CL  = 2;
    localparam int D2  = 4;
    localparam int PC2 = 16;
    localparam int CL2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_sequencer_if #(.Amba_Addr_Depth(D))  bus ();
    calc_sequencer_if #(.Amba_Addr_Depth(D2)) bus2 ();

    calc_sequencer #(.Amba_Addr_Depth(D), .Pixel_Count(PC), .Calc_Latency(CL)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    calc_sequencer #(.Amba_Addr_Depth(D2), .Pixel_Count(PC2), .Calc_Latency(CL2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position k within a pass timeline (0..PC-1 scan, then CL drain, then result).
    bit m_active, m_finished;
    int m_k, m_perf;

    task automatic model_reset();
        m_active = 0; m_finished = 0; m_k = 0; m_perf = 0;
    endtask

    task automatic model_step(input bit s);
        if (rst) begin
            model_reset();
        end else if (m_active) begin
            if (m_perf < 65535) m_perf++;
            if (m_k == PC + CL) begin
                m_active = 0; m_finished = 1;
            end else if (!s) m_active = 0;
            else m_k++;
        end else if (m_finished) begin
            if (!s) m_finished = 0;
        end else if (s) begin
            m_active = 1; m_k = 0; m_perf = 0;
        end
    endtask

    task automatic check_all();
        bit scan;
        scan = m_active && (m_k < PC);
        check("en_read", bus.en_read, scan);
        check("busy", bus.busy, m_active);
        check("get_result", bus.get_result, m_active && (m_k == PC + CL));
        check("done", bus.done, m_finished);
        if (m_active) check("mem_wr_en_busy", bus.mem_wr_en, 0);
        else          check("mem_wr_en_pass", bus.mem_wr_en, bus.wr_en & ~rst);
        if (scan)           check("mem_addr_scan", bus.mem_addr, m_k);
        else if (!m_active) check("mem_addr_pass", bus.mem_addr, bus.wr_addr);
`ifdef CALC_SEQ_PERF_CNT_EN
        check("pass_cycles", bus.pass_cycles, m_perf);
`endif
    endtask

    task automatic cycle(input bit s, input bit we, input logic [D-1:0] wa);
        bus.start = s; bus.wr_en = we; bus.wr_addr = wa;
        @(posedge clk);
        model_step(s);
        @(negedge clk);
        check_all();
    endtask

    int gr_cycle, done_cycle, gr_count;
    logic [D2-1:0] addr_q[$];

    initial begin
        bus.start = 0; bus.wr_en = 0; bus.wr_addr = '0;
        bus2.start = 0; bus2.wr_en = 0; bus2.wr_addr = '0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 0;
        cycle(0, 0, '0);

        // Directed pass: start rises in cycle 0
        gr_cycle = -1; done_cycle = -1; gr_count = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1'b1, D'(12'h3C0 + i));
            if (bus.get_result) begin gr_count++; if (gr_cycle < 0) gr_cycle = i + 1; end
            if (bus.done && done_cycle < 0) done_cycle = i + 1;
        end
        check("gr_cycle", gr_cycle, 1 + PC + CL);
        check("gr_count", gr_count, 1);
        check("done_cycle", done_cycle, 2 + PC + CL);
`ifdef CALC_SEQ_PERF_CNT_EN
        check("perf_done", bus.pass_cycles, PC + CL + 1);
`endif
        cycle(0, 0, '0);
        cycle(0, 0, '0);
`ifdef CALC_SEQ_PERF_CNT_EN
        check("perf_held", bus.pass_cycles, PC + CL + 1);
`endif

        // Idle write pass-through, same cycle
        bus.wr_en = 1; bus.wr_addr = 12'h0A5;
        #1;
        check("idle_wr_addr", bus.mem_addr, 12'h0A5);
        check("idle_wr_en", bus.mem_wr_en, 1);
        cycle(1, 1, 12'h0A5);
        cycle(1, 1, 12'h0A5);
        cycle(0, 0, '0);

        // Abort at address 2, then restart from 0
        cycle(0, 0, '0);
        cycle(1, 0, '0);
        cycle(1, 0, '0);
        cycle(1, 0, '0);
        check("abort_addr", bus.mem_addr, 2);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0);
        cycle(1, 0, '0);
        check("restart_addr", bus.mem_addr, 0);
        cycle(0, 0, '0);

        // Reset during DRAIN
        for (int i = 0; i < PC + 1; i++) cycle(1, 0, '0);
        check("in_drain", bus.busy & ~bus.en_read, 1);
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        cycle(0, 0, '0);
        rst = 0;
        for (int i = 0; i < PC + CL + 4; i++) cycle(0, 0, '0);

        // start held high through reset release
        cycle(1, 0, '0);
        rst = 1;
        cycle(1, 0, '0);
        rst = 0;
        cycle(1, 0, '0);
        check("start_thru_rst", bus.en_read, 1);
        cycle(0, 0, '0);

        // Randomized start levels and APB traffic
        for (int seg = 0; seg < 60; seg++) begin
            bit s;
            int len;
            s   = seg[0];
            len = s ? int'($urandom_range(1, PC + CL + 5)) : int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) cycle(s, 1'($urandom), D'($urandom));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, '0);

        // Full-depth scan on the second instance
        gr_cycle = -1;
        bus2.start = 1;
        for (int c = 1; c <= PC2 + CL2 + 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus2.en_read) addr_q.push_back(bus2.mem_addr);
            if (bus2.get_result && gr_cycle < 0) gr_cycle = c;
        end
        check("full_count", addr_q.size(), PC2);
        for (int i = 0; i < PC2; i++)
            if (i < addr_q.size()) check("full_addr", addr_q[i], i);
        check("full_gr_cycle", gr_cycle, 1 + PC2 + CL2);
        check("full_done", bus2.done, 1);
        bus2.start = 0;
        @(negedge clk);
        check("full_idle", bus2.done, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
